sha_msg_mem_responder: RTL and testbench
========================================

// Module: sha_msg_mem_responder
// PURPOSE
//  Synthesizable memory responder for the other end of the simplified_sha256 memory interface.
//  Serves core reads and writes (mem_we/mem_addr/mem_write_data/mem_read_data).
//  An on-chip generator fills a message region from a seed. A host read port fetches hash results.
//  Sits beside the hash core on the same clock; replaces the behavioural bench memory in hardware.
// PARAMETERS
//  DEPTH         16384  number of 32-bit words; addresses are taken modulo DEPTH
//  ADDR_W        16     address width of core and host ports
//  DATA_W        32     word width
//  NUM_OF_WORDS  20     words written per generator run (1..DEPTH)
// PORTS
//  clk             in   1       single clock; all ports are sampled on its rising edge
//  reset           in   1       synchronous, active-high
//  gen_start       in   1       request a generator run; sampled only in IDLE
//  gen_seed        in   DATA_W  first message word
//  gen_base        in   ADDR_W  address of the first message word
//  gen_busy        out  1       high while the generator owns the write path
//  gen_done        out  1       one-cycle pulse after the last generated write
//  mem_we          in   1       core write strobe; any cycle without it is a core read
//  mem_addr        in   ADDR_W  core address
//  mem_write_data  in   DATA_W  core write data
//  mem_read_data   out  DATA_W  core read data, registered
//  host_rd_en      in   1       host read request
//  host_rd_addr    in   ADDR_W  host read address
//  host_rd_data    out  DATA_W  host read data
//  host_rd_valid   out  1       host_rd_data is valid this cycle
//  stat_rd_cnt     out  32      core read count (see CONFIGURATION)
//  stat_wr_cnt     out  32      core write count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: gen_busy=0, gen_done=0, mem_read_data=0, host_rd_data=0, host_rd_valid=0, counters=0.
//   The RAM array is not cleared by reset.
//  FSM states: IDLE, GEN, DONE.
//   IDLE -> GEN on gen_start. Seed, base and cnt=0 are latched on that edge.
//   GEN: one write per cycle, word[cnt] to (base+cnt) mod DEPTH.
//   word[0]=seed; word[k]=rotl1(word[k-1]), i.e. {w[30:0],w[31]}.
//   GEN -> DONE after the write with cnt=NUM_OF_WORDS-1. DONE -> IDLE unconditionally.
//  Timing: gen_busy is high for exactly NUM_OF_WORDS cycles.
//   gen_done is high exactly in the DONE cycle.
//   gen_start in GEN or DONE is ignored and not queued.
//  Core read: mem_read_data = RAM[mem_addr] one cycle after the address is presented.
//   On a core write cycle mem_read_data holds its previous value.
//   Core write: RAM updated at the clock edge.
//  Generator priority: while gen_busy, core writes are dropped and mem_read_data is forced to 0.
//  Host read: host_rd_valid and host_rd_data come one cycle after host_rd_en.
//   host_rd_valid is low in cycles with no request. Back-to-back requests are served every cycle.
//  Same-address write and host read in one cycle: the host gets the old data (read-before-write).
//  Address wrap: (base+cnt) wraps modulo DEPTH. Core and host addresses are masked to log2(DEPTH) bits.
//  Reset mid-GEN: FSM returns to IDLE and gen_done does not pulse.
//   Words already written remain; the rest are untouched.
// CONFIGURATION
//  SHA_MEM_STATS_EN defined:
//   stat_rd_cnt/stat_wr_cnt count accepted core reads/writes.
//   Counts saturate at 32'hFFFFFFFF and clear on reset or an accepted gen_start.
//  Not defined: no counter logic; both ports are tied to 0 so the interface stays stable.
// STRUCTURE
//  Package sha_mem_pkg: ADDR_W/DATA_W constants, gen_state_t enum {IDLE,GEN,DONE},
//   function rotl1(logic [31:0]).
//  Sub-module sha_dpram: two-port RAM with one write/read port and one read-only port.
//   Both outputs are registered; read-before-write. Must infer block RAM.
//  The top level holds the FSM, generator counter, write mux/priority and stats counters.
// TESTING
//  1 seed=32'h01234675, base=0, N=20 -> RAM[0]=01234675, RAM[1]=02468CEA.
//    RAM[k]=rotl^k(seed); gen_busy high 20 cycles; gen_done one pulse in cycle 21.
//  2 core write 1000<-32'hDEADBEEF, then core read 1000 -> mem_read_data=DEADBEEF on the next cycle.
//    host read 1000 -> host_rd_valid=1 with DEADBEEF one cycle later.
//  3 base=16380, N=20 -> words 0..3 at 16380..16383 and words 4..19 at 0..15.
//  4 reset after 5 GEN writes -> gen_busy=0, no gen_done.
//    RAM[base..base+4] written; RAM[base+5..] unchanged.
//  5 core write 7<-A5A5A5A5 with host read 7 in the same cycle -> host_rd_data = old RAM[7].
//  6 gen_start pulsed during GEN, and a core write during GEN -> only one run;
//    core write dropped; mem_read_data=0. With SHA_MEM_STATS_EN, stat_wr_cnt is unchanged.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// Shared types and helpers for the SHA message memory responder.
// Holds the bus widths, the generator state enum and the word rotation.
package sha_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } gen_state_t;

  function automatic logic [31:0] rotl1(input logic [31:0] w);
    return {w[30:0], w[31]};
  endfunction

endpackage

// File: rtl/sha_dpram.sv
// Two-port block RAM: port A write/read, port B read-only.
// Both outputs are registered; reads return the pre-write contents.
module sha_dpram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          rd_en_a,
  input  logic          clr_a,
  output logic [DW-1:0] rdata_a,
  input  logic          rd_en_b,
  input  logic          clr_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
  end

  always_ff @(posedge clk) begin
    if (clr_a) rdata_a <= '0;
    else if (rd_en_a) rdata_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (clr_b) rdata_b <= '0;
    else if (rd_en_b) rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/sha_msg_mem_responder.sv
// Memory responder for the SHA core: core port, message generator, host read.
// Define SHA_MEM_STATS_EN to build the saturating core read/write counters.
module sha_msg_mem_responder #(
  parameter int DEPTH        = 16384,
  parameter int ADDR_W       = sha_mem_pkg::ADDR_W,
  parameter int DATA_W       = sha_mem_pkg::DATA_W,
  parameter int NUM_OF_WORDS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_start,
  input  logic [DATA_W-1:0] gen_seed,
  input  logic [ADDR_W-1:0] gen_base,
  output logic              gen_busy,
  output logic              gen_done,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  input  logic              host_rd_en,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_rd_valid,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt
);

  import sha_mem_pkg::*;

  localparam int AW = $clog2(DEPTH);

  gen_state_t        state;
  logic [AW-1:0]     cnt;
  logic [AW-1:0]     base_q;
  logic [DATA_W-1:0] word;
  logic              start_acc;
  logic              we_a;
  logic [AW-1:0]     addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              unused_hi;

  assign start_acc = (state == IDLE) && gen_start;

  // Generator owns port A while busy; reset also blocks a pending write.
  assign we_a    = !reset && (gen_busy || mem_we);
  assign addr_a  = gen_busy ? base_q + cnt : mem_addr[AW-1:0];
  assign wdata_a = gen_busy ? word : mem_write_data;

  assign unused_hi = ^{mem_addr[ADDR_W-1:AW],
                       host_rd_addr[ADDR_W-1:AW],
                       gen_base[ADDR_W-1:AW]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gen_busy <= 1'b0;
      gen_done <= 1'b0;
      cnt      <= '0;
      base_q   <= '0;
      word     <= '0;
    end else begin
      gen_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gen_start) begin
            state    <= GEN;
            gen_busy <= 1'b1;
            cnt      <= '0;
            base_q   <= gen_base[AW-1:0];
            word     <= gen_seed;
          end
        end
        GEN: begin
          cnt  <= cnt + 1'b1;
          word <= rotl1(word);
          if (cnt == AW'(NUM_OF_WORDS - 1)) begin
            state    <= DONE;
            gen_busy <= 1'b0;
            gen_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) host_rd_valid <= 1'b0;
    else host_rd_valid <= host_rd_en;
  end

  sha_dpram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DATA_W)
  ) u_ram (
    .clk    (clk),
    .we_a   (we_a),
    .addr_a (addr_a),
    .wdata_a(wdata_a),
    .rd_en_a(!mem_we),
    .clr_a  (reset || gen_busy || start_acc),
    .rdata_a(mem_read_data),
    .rd_en_b(host_rd_en),
    .clr_b  (reset),
    .addr_b (host_rd_addr[AW-1:0]),
    .rdata_b(host_rd_data)
  );

`ifdef SHA_MEM_STATS_EN
  logic rd_acc;
  logic wr_acc;

  assign rd_acc = !mem_we && !gen_busy;
  assign wr_acc = mem_we && !gen_busy;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (rd_acc && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1;
      if (wr_acc && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1;
    end
  end
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_sha_msg_mem_responder.sv
// Directed bench for sha_msg_mem_responder.
// Checks generator runs, core/host ports, wrap, mid-run reset and priority.
module tb_sha_msg_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        gen_start;
  logic [31:0] gen_seed;
  logic [15:0] gen_base;
  logic        gen_busy;
  logic        gen_done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        host_rd_en;
  logic [15:0] host_rd_addr;
  logic [31:0] host_rd_data;
  logic        host_rd_valid;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sha_msg_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .gen_start     (gen_start),
    .gen_seed      (gen_seed),
    .gen_base      (gen_base),
    .gen_busy      (gen_busy),
    .gen_done      (gen_done),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .host_rd_en    (host_rd_en),
    .host_rd_addr  (host_rd_addr),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_wr_cnt   (stat_wr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rot(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cwr(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_write_data = d;
    step();
    mem_we = 1'b0;
  endtask

  task automatic hrd(input logic [15:0] a, output logic [31:0] d);
    host_rd_en = 1'b1;
    host_rd_addr = a;
    step();
    host_rd_en = 1'b0;
    chk("hvalid", 32'(host_rd_valid), 32'd1);
    d = host_rd_data;
  endtask

  task automatic start(input logic [31:0] s, input logic [15:0] b);
    gen_start = 1'b1;
    gen_seed = s;
    gen_base = b;
    step();
    gen_start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((gen_busy || gen_done) && i < 40) begin
      step();
      i++;
    end
    chk("wait_idle", 32'(gen_busy), 32'd0);
  endtask

  logic [31:0] w, d;
  int nb, nd, di;

  initial begin
    reset = 1'b1;
    gen_start = 1'b0;
    gen_seed = '0;
    gen_base = '0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    host_rd_en = 1'b0;
    host_rd_addr = '0;
    step();
    step();
    chk("rst_busy", 32'(gen_busy), 32'd0);
    chk("rst_done", 32'(gen_done), 32'd0);
    chk("rst_mrd", mem_read_data, 32'd0);
    chk("rst_hrd", host_rd_data, 32'd0);
    chk("rst_hval", 32'(host_rd_valid), 32'd0);
    chk("rst_srd", stat_rd_cnt, 32'd0);
    chk("rst_swr", stat_wr_cnt, 32'd0);
    reset = 1'b0;
    step();

    // Run 1: base 0, 20 words, busy/done timing
    start(32'h01234675, 16'd0);
    nb = 0; nd = 0; di = -1;
    for (int i = 0; i < 25; i++) begin
      if (gen_busy) nb++;
      if (gen_done) begin nd++; di = i; end
      step();
    end
    chk("t1_busy_cycles", 32'(nb), 32'd20);
    chk("t1_done_pulses", 32'(nd), 32'd1);
    chk("t1_done_cycle", 32'(di), 32'd20);
    hrd(16'd1, d);
    chk("t1_ram1", d, 32'h02468CEA);
    w = 32'h01234675;
    for (int k = 0; k < 20; k++) begin
      hrd(16'(k), d);
      chk($sformatf("t1_ram%0d", k), d, w);
      w = rot(w);
    end
    step();
    chk("t1_hval_idle", 32'(host_rd_valid), 32'd0);

    // Core write/read, hold on write cycle, host read
    cwr(16'd1000, 32'hDEADBEEF);
    mem_addr = 16'd1000;
    step();
    chk("t2_core_rd", mem_read_data, 32'hDEADBEEF);
    cwr(16'd1001, 32'h11111111);
    chk("t2_hold_on_wr", mem_read_data, 32'hDEADBEEF);
    hrd(16'd1000, d);
    chk("t2_host_rd", d, 32'hDEADBEEF);

    // Wrap at the top of memory
    start(32'h80000001, 16'd16380);
    wait_idle();
    w = 32'h80000001;
    for (int k = 0; k < 20; k++) begin
      hrd(16'((16380 + k) % 16384), d);
      chk($sformatf("t3_word%0d", k), d, w);
      w = rot(w);
    end

    // Same-cycle write and host read returns old data
    cwr(16'd7, 32'h12345678);
    mem_we = 1'b1;
    mem_addr = 16'd7;
    mem_write_data = 32'hA5A5A5A5;
    host_rd_en = 1'b1;
    host_rd_addr = 16'd7;
    step();
    mem_we = 1'b0;
    host_rd_en = 1'b0;
    chk("t5_rbw", host_rd_data, 32'h12345678);
    hrd(16'd7, d);
    chk("t5_new", d, 32'hA5A5A5A5);

    // Reset after 5 generator writes
    for (int k = 0; k < 20; k++) cwr(16'(2000 + k), 32'hC0DE0000 + k);
    start(32'h0000F00D, 16'd2000);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_busy", 32'(gen_busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (gen_done || gen_busy) nd++;
      step();
    end
    chk("t4_no_done", 32'(nd), 32'd0);
    w = 32'h0000F00D;
    for (int k = 0; k < 20; k++) begin
      hrd(16'(2000 + k), d);
      chk($sformatf("t4_ram%0d", k), d, (k < 5) ? w : 32'hC0DE0000 + k);
      w = rot(w);
    end

    // gen_start and core write during a run
    cwr(16'd3100, 32'h5555AAAA);
    mem_addr = 16'd3100;
    start(32'h00000003, 16'd3000);
    nb = 0; nd = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 3) begin
        gen_start = 1'b1;
        mem_we = 1'b1;
        mem_addr = 16'd3100;
        mem_write_data = 32'hFFFF0000;
      end
      if (i == 4) begin
        gen_start = 1'b0;
        mem_we = 1'b0;
        chk("t6_mrd_zero", mem_read_data, 32'd0);
        chk("t6_swr_busy", stat_wr_cnt, 32'd0);
        chk("t6_srd_busy", stat_rd_cnt, 32'd0);
      end
      if (gen_busy) nb++;
      if (gen_done) nd++;
      step();
    end
    chk("t6_busy_cycles", 32'(nb), 32'd20);
    chk("t6_done_pulses", 32'(nd), 32'd1);
    hrd(16'd3100, d);
    chk("t6_dropped", d, 32'h5555AAAA);
    hrd(16'd3019, d);
    w = 32'h00000003;
    for (int k = 0; k < 19; k++) w = rot(w);
    chk("t6_last_word", d, w);
    cwr(16'd50, 32'h1);
    cwr(16'd51, 32'h2);
    cwr(16'd52, 32'h3);
`ifdef SHA_MEM_STATS_EN
    chk("t6_swr_after", stat_wr_cnt, 32'd3);
`else
    chk("t6_swr_after", stat_wr_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
